if_stage_unit: RTL and testbench
================================

# if_stage_unit

Instruction-fetch stage of the pipelined MIPS CPU: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register consumed by decode and the hazard unit. It holds state on a load-use stall. It converts the IF/ID contents into a NOP bubble on a flush. It redirects the PC to a branch/jump target resolved downstream. It also keeps a saturating stall counter for performance debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of stall counter

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID this cycle (load-use hazard)
- flush  input  1  replace IF/ID contents with a bubble at the next edge
- redirect_valid  input  1  load PC from redirect_target at the next edge
- redirect_target  input  32  branch/jump target address
- imem_addr  output  32  instruction-memory read address (combinational read memory)
- imem_rdata  input  32  instruction word at imem_addr, same cycle
- pc  output  32  current PC register
- id_instr  output  32  IF/ID instruction word
- id_pc4  output  32  IF/ID PC+4 of that instruction
- id_valid  output  1  IF/ID holds a real fetched instruction
- misalign_err  output  1  sticky: a redirect target with bits [1:0] != 0 was seen
- stall_cnt  output  CNT_W  number of cycles with stall applied, saturating

## Operation
- imem_addr = pc, combinational.
- PC next-state priority: rst > redirect_valid > stall > pc+4.
  - rst → RESET_PC.
  - redirect_valid → {redirect_target[31:2], 2'b00}. Redirect overrides a simultaneous stall.
  - stall → hold.
  - otherwise → pc+4. 32-bit modular: 32'hFFFF_FFFC + 4 = 0.
- IF/ID next-state priority: rst > (flush | redirect_valid) > stall > load.
  - bubble → id_instr=0 (NOP), id_pc4=0, id_valid=0.
  - stall → hold all three fields.
  - load → id_instr=imem_rdata, id_pc4=pc+4, id_valid=1.
- The instruction word 0 is the architectural NOP. Downstream logic treats it as a no-op bubble.
- misalign_err:
  - Set at an edge where redirect_valid=1 and redirect_target[1:0]!=0.
  - Cleared only by rst.
  - The redirect still proceeds with the masked target.
- stall_cnt:
  - Increments at each edge where stall=1, including edges where redirect/flush override the stall.
  - Saturates at all-ones.
  - Cleared by rst.

## Timing
- Reset values:
  - pc=RESET_PC, id_instr=0, id_pc4=0, id_valid=0, misalign_err=0, stall_cnt=0.
  - imem_addr=RESET_PC in the first cycle after rst deasserts.
- Fetch-to-decode latency:
  - The word at imem_addr in cycle N appears on id_instr in cycle N+1.
  - One instruction per cycle in steady state.
- Stall:
  - stall high in cycle N → pc, imem_addr and IF/ID identical in N+1.
  - Fetch resumes the cycle after stall drops.
  - No instruction is lost or duplicated.
- Redirect:
  - redirect_valid in cycle N → imem_addr=target in N+1.
  - IF/ID is a bubble in N+1.
  - The target instruction appears in IF/ID in N+2.
- flush without redirect in cycle N:
  - Bubble in N+1.
  - PC follows its own priority (holds if stall, else +4).
- rst asserted mid-operation: all state returns to reset values at that edge, regardless of stall/flush/redirect.
- Inputs are sampled only at the rising edge. Outputs other than imem_addr change only after the edge.

## Test plan
- Reset then free-run with imem_rdata = address-derived words → pc steps 0,4,8,…; id_instr(N+1)=word(pc(N)); id_pc4 = pc+4; id_valid=1 from the second cycle.
- stall high for 3 cycles at pc=0x10 → pc, id_instr, id_pc4 frozen for 3 cycles; stall_cnt=3; next fetch is 0x14, no duplicate in IF/ID.
- redirect_valid with target 0x200 and stall both high at pc=0x40 → imem_addr=0x200 next cycle; IF/ID bubble (0/0/0); word(0x200) in IF/ID one cycle later; stall_cnt increments.
- redirect_target=0x103 → pc=0x100; misalign_err=1 and remains 1 through later redirects until rst.
- RESET_PC=32'hFFFF_FFF8, free-run → pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; id_pc4=0 for the 0xFFFF_FFFC fetch.
- Force stall for 2^CNT_W+5 cycles, then assert rst mid-stall → stall_cnt holds at all-ones, then all outputs return to reset values at the rst edge.

Source files
------------

// File: rtl/if_stage_unit.sv
// ----------------------------------------------------------------------------
// if_stage_unit
//
// Instruction-fetch stage of the pipelined MIPS core. Owns the program
// counter, presents it as the instruction-memory read address and captures
// the fetched word into the IF/ID pipeline register for decode and the
// hazard unit. Supports load-use stalls, flush bubbles, redirects to a
// branch/jump target resolved downstream, a sticky misaligned-target flag
// and a saturating stall-cycle counter for performance debug.
//
// Parameters
//   RESET_PC  PC value loaded on reset
//   CNT_W     width of the stall counter
//
// Ports
//   clk              in   clock, all state updates on rising edge
//   rst              in   synchronous active-high reset
//   stall            in   hold PC and IF/ID this cycle
//   flush            in   turn IF/ID into a bubble at the next edge
//   redirect_valid   in   load PC from redirect_target at the next edge
//   redirect_target  in   branch/jump target (low two bits are masked)
//   imem_addr        out  instruction-memory read address (= pc)
//   imem_rdata       in   instruction word at imem_addr, same cycle
//   pc               out  current PC register
//   id_instr         out  IF/ID instruction word (0 = NOP bubble)
//   id_pc4           out  IF/ID PC+4 of that instruction
//   id_valid         out  IF/ID holds a real fetched instruction
//   misalign_err     out  sticky: a misaligned redirect target was seen
//   stall_cnt        out  saturating count of stalled cycles
// ----------------------------------------------------------------------------
module if_stage_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc4,
   output logic             id_valid,
   output logic             misalign_err,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [31:0] pc_plus4;
   logic        bubble;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Modular 32-bit add: the top of the address space wraps to 0.
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;

   // A redirect squashes the wrong-path word being fetched this cycle.
   assign bubble = flush | redirect_valid;

   // ---- IF -> IF/ID boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         id_instr     <= 32'd0;
         id_pc4       <= 32'd0;
         id_valid     <= 1'b0;
         misalign_err <= 1'b0;
         stall_cnt    <= '0;
      end else begin
         if (redirect_valid)
            pc <= {redirect_target[31:2], 2'b00};
         else if (!stall)
            pc <= pc_plus4;

         if (bubble) begin
            id_instr <= 32'd0;
            id_pc4   <= 32'd0;
            id_valid <= 1'b0;
         end else if (!stall) begin
            id_instr <= imem_rdata;
            id_pc4   <= pc_plus4;
            id_valid <= 1'b1;
         end

         if (redirect_valid && (redirect_target[1:0] != 2'b00))
            misalign_err <= 1'b1;

         // Counts every stalled edge, even when a redirect/flush overrides it.
         if (stall)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_if_stage_unit.sv
module tb_if_stage_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: default parameters.
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic        misalign_err;
   logic [15:0] stall_cnt;

   // Second instance: top-of-address-space reset PC, narrow counter.
   logic        w_rst = 1'b1;
   logic        w_stall = 1'b0;
   logic        w_flush = 1'b0;
   logic        w_redirect_valid = 1'b0;
   logic [31:0] w_redirect_target = 32'd0;
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic [31:0] w_pc;
   logic [31:0] w_id_instr;
   logic [31:0] w_id_pc4;
   logic        w_id_valid;
   logic        w_misalign_err;
   logic [3:0]  w_stall_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Address-derived instruction words, never zero.
   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign imem_rdata   = word(imem_addr);
   assign w_imem_rdata = word(w_imem_addr);

   if_stage_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
      .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
      .misalign_err(misalign_err), .stall_cnt(stall_cnt)
   );

   if_stage_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut_w (
      .clk(clk), .rst(w_rst), .stall(w_stall), .flush(w_flush),
      .redirect_valid(w_redirect_valid), .redirect_target(w_redirect_target),
      .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata), .pc(w_pc),
      .id_instr(w_id_instr), .id_pc4(w_id_pc4), .id_valid(w_id_valid),
      .misalign_err(w_misalign_err), .stall_cnt(w_stall_cnt)
   );

   // Reference model state for the main instance.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic        m_mis;
   int          m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"},        pc,               m_pc);
      chk({tag, ".imem_addr"}, imem_addr,        m_pc);
      chk({tag, ".id_instr"},  id_instr,         m_instr);
      chk({tag, ".id_pc4"},    id_pc4,           m_pc4);
      chk({tag, ".id_valid"},  32'(id_valid),    32'(m_valid));
      chk({tag, ".misalign"},  32'(misalign_err), 32'(m_mis));
      chk({tag, ".stall_cnt"}, 32'(stall_cnt),   32'(m_cnt));
   endtask

   // Apply one cycle of inputs, advance the model by the stage's rules,
   // then compare after the edge.
   task automatic step(input logic s, input logic f, input logic rv,
                       input logic [31:0] rt, input string tag);
      logic [31:0] fetched;
      fetched = word(m_pc);
      stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
      if (f || rv) begin
         m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (!s) begin
         m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (rv)
         m_pc = rt & 32'hFFFF_FFFC;
      else if (!s)
         m_pc = m_pc + 32'd4;
      if (rv && (rt % 4 != 0)) m_mis = 1'b1;
      if (s && m_cnt < 65535) m_cnt = m_cnt + 1;
      @(posedge clk); #1;
      chk_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      stall = 1'($urandom);
      flush = 1'($urandom);
      redirect_valid = 1'b1;
      redirect_target = $urandom;
      @(posedge clk); #1;
      m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
      m_valid = 1'b0; m_mis = 1'b0; m_cnt = 0;
      chk_all(tag);
      rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      logic s, f, rv;
      logic [31:0] rt;

      // ---- wrap-around instance ----
      @(posedge clk); #1;
      w_rst = 1'b0;
      chk("w.reset_pc",   w_pc,        32'hFFFF_FFF8);
      chk("w.reset_addr", w_imem_addr, 32'hFFFF_FFF8);
      chk("w.reset_valid", 32'(w_id_valid), 32'd0);
      @(posedge clk); #1;
      chk("w.pc1",    w_pc,       32'hFFFF_FFFC);
      chk("w.instr1", w_id_instr, 32'hFFF8_0007);
      chk("w.pc4_1",  w_id_pc4,   32'hFFFF_FFFC);
      @(posedge clk); #1;
      chk("w.pc2",    w_pc,       32'h0000_0000);
      chk("w.instr2", w_id_instr, 32'hFFFC_0003);
      chk("w.pc4_2",  w_id_pc4,   32'h0000_0000);
      chk("w.valid2", 32'(w_id_valid), 32'd1);
      w_stall = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      chk("w.sat_cnt", 32'(w_stall_cnt), 32'h0000_000F);
      chk("w.sat_pc",  w_pc,             32'h0000_0000);
      w_rst = 1'b1;
      @(posedge clk); #1;
      chk("w.rst_pc",    w_pc,              32'hFFFF_FFF8);
      chk("w.rst_instr", w_id_instr,        32'd0);
      chk("w.rst_pc4",   w_id_pc4,          32'd0);
      chk("w.rst_valid", 32'(w_id_valid),   32'd0);
      chk("w.rst_cnt",   32'(w_stall_cnt),  32'd0);
      w_rst = 1'b0; w_stall = 1'b0;

      // ---- main instance: free run ----
      do_reset("reset");
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "run");
      chk("pc_at_0x10", pc, 32'h10);

      // ---- three-cycle stall at 0x10 ----
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "stall");
      chk("stall_pc",  pc,              32'h10);
      chk("stall_cnt", 32'(stall_cnt),  32'd3);
      step(0, 0, 0, 0, "resume");
      chk("resume_pc",    pc,       32'h14);
      chk("resume_instr", id_instr, word(32'h10));

      // ---- redirect + stall at 0x40 ----
      while (m_pc != 32'h40) step(0, 0, 0, 0, "run2");
      step(1, 0, 1, 32'h200, "redir_stall");
      chk("redir_addr",  imem_addr,       32'h200);
      chk("redir_valid", 32'(id_valid),   32'd0);
      chk("redir_cnt",   32'(stall_cnt),  32'd4);
      step(0, 0, 0, 0, "redir_next");
      chk("redir_word", id_instr, word(32'h200));

      // ---- misaligned target, then sticky through aligned redirects ----
      step(0, 0, 1, 32'h103, "misalign");
      chk("mis_pc",   pc,                 32'h100);
      chk("mis_flag", 32'(misalign_err),  32'd1);
      step(0, 0, 1, 32'h300, "redir_aligned");
      step(0, 0, 0, 0, "run3");
      chk("mis_sticky", 32'(misalign_err), 32'd1);

      // ---- flush alone and flush with stall ----
      step(0, 1, 0, 0, "flush");
      step(1, 1, 0, 0, "flush_stall");
      step(0, 0, 0, 0, "run4");

      // ---- random traffic ----
      do_reset("reset2");
      for (int i = 0; i < 400; i++) begin
         s  = ($urandom_range(3) == 0);
         f  = ($urandom_range(7) == 0);
         rv = ($urandom_range(7) == 0);
         rt = $urandom;
         step(s, f, rv, rt, "rand");
      end

      // ---- counter saturation, then reset mid-stall ----
      do_reset("reset3");
      for (int i = 0; i < 65536 + 5; i++) step(1, 0, 0, 0, "sat");
      chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
      do_reset("rst_mid_stall");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
